// File: rtl/piso_pkg.sv
// Shared constants for the parallel-in, serial-out shifter: FSM state codes and shift direction.
package piso_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_SHIFT  = 1'b1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/piso_shift_register_if.sv
// Load-side and serial-side handshake bundle of the PISO shifter.
interface piso_shift_register_if #(
    parameter int unsigned N = 4
);

    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         left_right_mode;
    logic         serial_valid;
    logic         serial_ready;
    logic         serial_out;
    logic         serial_last;
    logic         busy;

    // The shifter itself.
    modport slave (
        input  load_valid,
        input  load_data,
        input  left_right_mode,
        input  serial_ready,
        output load_ready,
        output serial_valid,
        output serial_out,
        output serial_last,
        output busy
    );

    // Word producer and serial consumer.
    modport master (
        output load_valid,
        output load_data,
        output left_right_mode,
        output serial_ready,
        input  load_ready,
        input  serial_valid,
        input  serial_out,
        input  serial_last,
        input  busy
    );

endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shifter: loads an N-bit word over valid/ready and emits it one bit
// per accepted serial transfer, MSB-first or LSB-first as chosen at load time.
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input logic                  clk,
    input logic                  reset,
    piso_shift_register_if.slave bus
);

    localparam int unsigned CntW = $clog2(N + 1);

    logic            state_q, state_d;
    logic [N-1:0]    shift_reg_q, shift_reg_d;
    logic            dir_q, dir_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic            in_shift;
    logic            xfer;

    assign in_shift = (state_q == ST_SHIFT);
    assign xfer     = in_shift && bus.serial_ready;

    // Outputs decode from registered state only; serial_ready never reaches them.
    always_comb begin
        bus.load_ready   = !in_shift;
        bus.busy         = in_shift;
        bus.serial_valid = in_shift;
        bus.serial_last  = in_shift && (bit_cnt_q == CntW'(1));
        bus.serial_out   = in_shift &&
                           ((dir_q == DIR_RIGHT) ? shift_reg_q[0] : shift_reg_q[N-1]);
    end

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        dir_d       = dir_q;
        bit_cnt_d   = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    shift_reg_d = bus.load_data;
                    dir_d       = bus.left_right_mode;
                    bit_cnt_d   = CntW'(N);
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    if (dir_q == DIR_LEFT) begin
                        shift_reg_d = {shift_reg_q[N-2:0], 1'b0};
                    end else begin
                        shift_reg_d = {1'b0, shift_reg_q[N-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q - CntW'(1);
                    if (bit_cnt_q == CntW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_reg_q <= '0;
            dir_q       <= DIR_LEFT;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            dir_q       <= dir_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: directed vector table, hand-written stall sequence and
// randomized traffic checked against a bit-queue reference model.
module tb_piso_shift_register;

    localparam int unsigned N = 4;

    logic clk;
    logic reset;

    piso_shift_register_if #(.N(N)) bus ();

    piso_shift_register #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         lv;
        logic [N-1:0] data;
        logic         mode;
        logic         rdy;
        logic [4:0]   exp;   // {load_ready, serial_valid, serial_out, serial_last, busy}
        string        name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: bits still owed on the serial side, front = current bit.
    logic model_q[$];

    task automatic add(input logic rst, input logic lv, input logic [N-1:0] data,
                       input logic mode, input logic rdy, input logic [4:0] exp,
                       input string name);
        vec_t v;
        v.rst = rst; v.lv = lv; v.data = data; v.mode = mode; v.rdy = rdy;
        v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    function automatic logic [4:0] model_exp();
        logic sv;
        sv = (model_q.size() != 0);
        return {!sv, sv, sv ? model_q[0] : 1'b0, model_q.size() == 1, sv};
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {bus.load_ready, bus.serial_valid, bus.serial_out, bus.serial_last, bus.busy};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got lr/sv/so/sl/busy=%b want %b at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and return at the following negedge.
    task automatic cyc(input logic rst, input logic lv, input logic [N-1:0] data,
                       input logic mode, input logic rdy);
        reset               = rst;
        bus.load_valid      = lv;
        bus.load_data       = data;
        bus.left_right_mode = mode;
        bus.serial_ready    = rdy;
        if (rst) begin
            model_q.delete();
        end else if (model_q.size() != 0) begin
            if (rdy) void'(model_q.pop_front());
        end else if (lv) begin
            for (int i = 0; i < N; i++) model_q.push_back(mode ? data[i] : data[N-1-i]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [4:0] IDLE = 5'b10000;

    initial begin
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.left_right_mode = 1'b0;
        bus.serial_ready = 1'b0;

        // Reset and idle.
        add(1, 0, 4'b0000, 0, 0, IDLE, "reset0");
        add(1, 0, 4'b0000, 0, 0, IDLE, "reset1");
        for (int i = 0; i < 5; i++) add(0, 0, 4'b0000, 0, 0, IDLE, "idle");
        // 1011 MSB first: 1,0,1,1.
        add(0, 1, 4'b1011, 0, 1, 5'b01101, "l_b1");
        add(0, 0, 4'b0000, 0, 1, 5'b01001, "l_b2");
        add(0, 0, 4'b0000, 0, 1, 5'b01101, "l_b3");
        add(0, 0, 4'b0000, 0, 1, 5'b01111, "l_b4");
        add(0, 0, 4'b0000, 0, 1, IDLE,     "l_done");
        // 1011 LSB first: 1,1,0,1.
        add(0, 1, 4'b1011, 1, 1, 5'b01101, "r_b1");
        add(0, 0, 4'b0000, 0, 1, 5'b01101, "r_b2");
        add(0, 0, 4'b0000, 0, 1, 5'b01001, "r_b3");
        add(0, 0, 4'b0000, 0, 1, 5'b01111, "r_b4");
        add(0, 0, 4'b0000, 0, 1, IDLE,     "r_done");
        // 1100 MSB first with ready pattern 1,0,0,1,1,0,1.
        add(0, 1, 4'b1100, 0, 0, 5'b01101, "st_b1");
        add(0, 0, 4'b0000, 0, 1, 5'b01101, "st_b2");
        add(0, 0, 4'b0000, 0, 0, 5'b01101, "st_hold2a");
        add(0, 0, 4'b0000, 0, 0, 5'b01101, "st_hold2b");
        add(0, 0, 4'b0000, 0, 1, 5'b01001, "st_b3");
        add(0, 0, 4'b0000, 0, 1, 5'b01011, "st_b4");
        add(0, 0, 4'b0000, 0, 0, 5'b01011, "st_hold4");
        add(0, 0, 4'b0000, 0, 1, IDLE,     "st_done");
        // 1001 MSB first; load_valid with 0110 and toggling mode while shifting is ignored.
        add(0, 1, 4'b1001, 0, 1, 5'b01101, "ign_b1");
        add(0, 1, 4'b0110, 1, 1, 5'b01001, "ign_b2");
        add(0, 1, 4'b0110, 0, 1, 5'b01001, "ign_b3");
        add(0, 1, 4'b0110, 1, 1, 5'b01111, "ign_b4");
        add(0, 1, 4'b0110, 1, 1, IDLE,     "ign_done");
        add(0, 0, 4'b0000, 0, 1, IDLE,     "ign_idle");
        // 1111 aborted by reset after two transfers; reset beats a concurrent load.
        add(0, 1, 4'b1111, 0, 1, 5'b01101, "ab_b1");
        add(0, 0, 4'b0000, 0, 1, 5'b01101, "ab_b2");
        add(0, 0, 4'b0000, 0, 1, 5'b01101, "ab_b3");
        add(1, 1, 4'b1010, 0, 1, IDLE,     "ab_reset");
        // 0001 LSB first: 1,0,0,0.
        add(0, 1, 4'b0001, 1, 1, 5'b01101, "post_b1");
        add(0, 0, 4'b0000, 0, 1, 5'b01001, "post_b2");
        add(0, 0, 4'b0000, 0, 1, 5'b01001, "post_b3");
        add(0, 0, 4'b0000, 0, 1, 5'b01011, "post_b4");
        add(0, 0, 4'b0000, 0, 1, IDLE,     "post_done");

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].lv, vecs[i].data, vecs[i].mode, vecs[i].rdy);
            check(vecs[i].name, vecs[i].exp);
        end

        // Long stall on the first bit of 0110 LSB-first; outputs must not follow
        // serial_ready or load_valid combinationally.
        cyc(0, 1, 4'b0110, 1, 0);
        check("stall_load", 5'b01001);
        for (int i = 0; i < 20; i++) begin
            cyc(0, i[0], 4'b1111, !i[1], 0);
            check("stall_hold", 5'b01001);
        end
        bus.serial_ready = 1'b1;
        bus.load_valid   = 1'b1;
        #1;
        check("comb_indep", 5'b01001);
        cyc(0, 0, 4'b0000, 0, 1);
        check("stall_b2", 5'b01101);
        cyc(0, 0, 4'b0000, 0, 1);
        check("stall_b3", 5'b01101);
        cyc(0, 0, 4'b0000, 0, 1);
        check("stall_b4", 5'b01011);
        cyc(0, 0, 4'b0000, 0, 1);
        check("stall_done", IDLE);

        // Randomized traffic against the reference model.
        cyc(1, 0, 4'b0000, 0, 0);
        check("rand_reset", model_exp());
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0), $urandom_range(0, 1), N'($urandom),
                $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
            check("rand", model_exp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
